// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multicycle CPU control FSM with memory wait timeout and retire counter.
// Revision : 1.0
// ============================================================================
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16,
  parameter int ALU_W       = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic [1:0]       funct,
  input  logic             zero,
  input  logic             carry,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             pc_write,
  output logic             branch,
  output logic             jal,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic [2:0]       state,
  output logic             halted,
  output logic             timeout_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] c_st_if   = 3'b000;
  localparam logic [2:0] c_st_id   = 3'b001;
  localparam logic [2:0] c_st_ex   = 3'b010;
  localparam logic [2:0] c_st_mem  = 3'b011;
  localparam logic [2:0] c_st_wb   = 3'b100;
  localparam logic [2:0] c_st_halt = 3'b101;

  // Counter only needs to reach MEM_TIMEOUT-1; the fault fires at that value.
  localparam int c_wait_w = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(MEM_TIMEOUT - 1);

  logic [2:0]          r_state;
  logic [c_wait_w-1:0] r_wait;
  logic [CNT_W-1:0]    r_count;
  logic                r_terr;

  logic [2:0]          w_next;
  logic [c_wait_w-1:0] w_wait_next;
  logic                w_timeout;

  logic w_add, w_adc, w_ndu, w_ndz, w_sw, w_lw, w_beq, w_jal, w_hlt;

  assign w_add = (opcode == 4'b0000) && (funct == 2'b00);
  assign w_adc = (opcode == 4'b0000) && (funct == 2'b10);
  assign w_ndu = (opcode == 4'b0010) && (funct == 2'b00);
  assign w_ndz = (opcode == 4'b0010) && (funct == 2'b01);
  assign w_sw  = (opcode == 4'b1001);
  assign w_lw  = (opcode == 4'b1010);
  assign w_beq = (opcode == 4'b1011);
  assign w_jal = (opcode == 4'b1101);
  assign w_hlt = (opcode == 4'b1111);

  // Wait count survives only while parked in the same waiting state.
  always_comb begin
    w_next      = r_state;
    w_wait_next = '0;
    w_timeout   = 1'b0;
    case (r_state)
      c_st_if, c_st_mem: begin
        if (mem_ready) begin
          w_next = (r_state == c_st_if) ? c_st_id : c_st_wb;
        end else if (r_wait == c_wait_max) begin
          w_next    = c_st_halt;
          w_timeout = 1'b1;
        end else begin
          w_wait_next = r_wait + 1'b1;
        end
      end
      c_st_id:   w_next = w_jal ? c_st_wb : (w_hlt ? c_st_halt : c_st_ex);
      c_st_ex:   w_next = (w_lw || w_sw) ? c_st_mem : c_st_wb;
      c_st_wb:   w_next = c_st_if;
      c_st_halt: w_next = c_st_halt;
      default:   w_next = c_st_if;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_if;
      r_wait  <= '0;
      r_count <= '0;
      r_terr  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_next;
      if (w_timeout) begin
        r_terr <= 1'b1;
      end
      if (r_state == c_st_wb) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    branch    = 1'b0;
    jal       = 1'b0;
    alu_ctrl  = '0;
    case (r_state)
      c_st_if: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        // No instruction capture while reset holds the FSM in IF.
        ir_write = mem_ready && !reset;
      end
      c_st_ex: begin
        if (w_ndu || w_ndz) begin
          alu_ctrl[0] = 1'b1;
        end else if (w_beq) begin
          alu_ctrl[1] = 1'b1;
        end
      end
      c_st_mem: begin
        mem_req   = 1'b1;
        mem_read  = w_lw;
        mem_write = w_sw;
      end
      c_st_wb: begin
        pc_write  = 1'b1;
        branch    = w_beq && zero;
        jal       = w_jal;
        reg_write = w_add || (w_adc && carry) || w_ndu || (w_ndz && zero) || w_lw || w_jal;
      end
      default: ;
    endcase
  end

  assign state       = r_state;
  assign halted      = (r_state == c_st_halt);
  assign timeout_err = r_terr;
  assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Self-checking bench for multicycle_ctrl against a phase-list model.
// Revision : 1.0
// ============================================================================
module tb_multicycle_ctrl;
  localparam int TO = 4;
  localparam int CW = 2;
  localparam int AW = 3;

  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3,
                         S_WB = 3'd4, S_HALT = 3'd5;
  localparam int K_NOP = 0, K_ADD = 1, K_ADC = 2, K_NDU = 3, K_NDZ = 4,
                 K_SW = 5, K_LW = 6, K_BEQ = 7, K_JAL = 8, K_HLT = 9;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] opcode;
  logic [1:0] funct;
  logic zero, carry, mem_ready;
  logic mem_req, mem_read, mem_write, ir_write, reg_write, pc_write, branch, jal;
  logic [AW-1:0] alu_ctrl;
  logic [2:0] state;
  logic halted, timeout_err;
  logic [CW-1:0] instr_count;

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW), .ALU_W(AW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .carry(carry), .mem_ready(mem_ready), .mem_req(mem_req), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .pc_write(pc_write), .branch(branch), .jal(jal), .alu_ctrl(alu_ctrl),
    .state(state), .halted(halted), .timeout_err(timeout_err),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: each instruction is a list of phases walked in order.
  logic [2:0] m_phases[$];
  int m_idx, m_wait, m_count;
  bit m_terr, m_halt, m_start;

  function automatic int cls(logic [3:0] op, logic [1:0] fn);
    if (op == 4'b0000 && fn == 2'b00) return K_ADD;
    if (op == 4'b0000 && fn == 2'b10) return K_ADC;
    if (op == 4'b0010 && fn == 2'b00) return K_NDU;
    if (op == 4'b0010 && fn == 2'b01) return K_NDZ;
    if (op == 4'b1001) return K_SW;
    if (op == 4'b1010) return K_LW;
    if (op == 4'b1011) return K_BEQ;
    if (op == 4'b1101) return K_JAL;
    if (op == 4'b1111) return K_HLT;
    return K_NOP;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [1:0] fn);
    int k;
    opcode = op;
    funct  = fn;
    k = cls(op, fn);
    m_phases = {S_IF, S_ID};
    if (k == K_JAL) begin
      m_phases.push_back(S_WB);
    end else if (k != K_HLT) begin
      m_phases.push_back(S_EX);
      if (k == K_LW || k == K_SW) m_phases.push_back(S_MEM);
      m_phases.push_back(S_WB);
    end
    m_idx   = 0;
    m_start = 0;
  endtask

  // One clock: compare at negedge, then advance the model at the posedge.
  task automatic step();
    int k;
    logic [2:0] cur;
    logic [AW-1:0] e_alu;
    logic [7:0] e_vec;
    @(negedge clk);
    k   = cls(opcode, funct);
    cur = m_halt ? S_HALT : m_phases[m_idx];
    e_alu = '0;
    if (cur == S_EX && (k == K_NDU || k == K_NDZ)) e_alu = 1;
    if (cur == S_EX && k == K_BEQ) e_alu = 2;
    e_vec = {cur == S_IF || cur == S_MEM,
             cur == S_IF || (cur == S_MEM && k == K_LW),
             cur == S_MEM && k == K_SW,
             cur == S_IF && mem_ready,
             cur == S_WB && (k == K_ADD || (k == K_ADC && carry) || k == K_NDU ||
                             (k == K_NDZ && zero) || k == K_LW || k == K_JAL),
             cur == S_WB,
             cur == S_WB && k == K_BEQ && zero,
             cur == S_WB && k == K_JAL};
    chk("state", state, cur);
    chk("strobes", {mem_req, mem_read, mem_write, ir_write, reg_write, pc_write, branch, jal}, e_vec);
    chk("alu_ctrl", alu_ctrl, e_alu);
    chk("halt_terr", {halted, timeout_err}, {cur == S_HALT, m_terr});
    chk("instr_count", instr_count, m_count[CW-1:0]);
    @(posedge clk);
    case (cur)
      S_IF, S_MEM: begin
        if (mem_ready) begin
          m_wait = 0;
          m_idx++;
        end else if (m_wait == TO - 1) begin
          m_halt = 1;
          m_terr = 1;
        end else begin
          m_wait++;
        end
      end
      S_ID: if (k == K_HLT) m_halt = 1; else m_idx++;
      S_EX: m_idx++;
      S_WB: begin
        m_count = (m_count + 1) % (1 << CW);
        m_idx   = 0;
        m_start = 1;
      end
      default: ;
    endcase
    #1;
  endtask

  // Reset is raised between clock edges to exercise its asynchronous path.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("rst_state", state, 3'b000);
    chk("rst_outs", {mem_req, mem_read, mem_write, ir_write, reg_write, pc_write,
                     branch, jal, halted, timeout_err}, 10'b1100000000);
    chk("rst_cnt", {alu_ctrl, instr_count}, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold", state, 3'b000);
    reset   = 1'b0;
    m_wait  = 0;
    m_count = 0;
    m_terr  = 0;
    m_halt  = 0;
    set_instr(4'b0001, 2'b00);
    m_start = 1;
  endtask

  task automatic pick_instr();
    int r;
    r = $urandom_range(0, 19);
    case (r)
      0: set_instr(4'b0000, 2'b00);
      1: set_instr(4'b0000, 2'b10);
      2: set_instr(4'b0010, 2'b00);
      3: set_instr(4'b0010, 2'b01);
      4: set_instr(4'b1001, 2'($urandom));
      5, 6: set_instr(4'b1010, 2'($urandom));
      7, 8: set_instr(4'b1011, 2'($urandom));
      9: set_instr(4'b1101, 2'($urandom));
      19: set_instr(4'b1111, 2'($urandom));
      default: set_instr(4'($urandom), 2'($urandom));
    endcase
  endtask

  initial begin
    logic [2:0] seq [5];
    logic [1:0] cnt_seq [5];
    reset = 1'b0;
    opcode = '0;
    funct = '0;
    zero = 1'b0;
    carry = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // ADD with memory always ready walks IF, ID, EX, WB, IF.
    seq = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b000};
    set_instr(4'b0000, 2'b00);
    for (int i = 0; i < 4; i++) begin
      chk("add_seq", state, seq[i]);
      if (i == 3) chk("add_regw", reg_write, 1'b1);
      else chk("add_regw", reg_write, 1'b0);
      step();
    end
    chk("add_seq", state, seq[4]);
    chk("add_cnt", instr_count, 2'd1);

    // LW stalled three cycles in MEM takes eight cycles total.
    set_instr(4'b1010, 2'b00);
    for (int i = 0; i < 8; i++) begin
      mem_ready = !(i >= 3 && i <= 5);
      if (i >= 3 && i <= 6) chk("lw_mem", {state, mem_read}, {S_MEM, 1'b1});
      step();
    end
    chk("lw_done", {state, instr_count}, {3'b000, 2'd2});

    // BEQ taken: branch and pc_write both high in WB.
    zero = 1'b1;
    set_instr(4'b1011, 2'b00);
    step(); step();
    chk("beq_alu", alu_ctrl, 3'b010);
    step();
    chk("beq_wb", {state, branch, pc_write}, {S_WB, 1'b1, 1'b1});
    step();

    // Memory never ready in IF: halt on the fourth IF edge.
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("to_wait", state, 3'b000);
    step();
    chk("to_halt", {state, halted, timeout_err}, {S_HALT, 1'b1, 1'b1});
    step(); step();
    chk("to_sticky", {halted, timeout_err}, 2'b11);
    do_reset();

    // Five NOPs wrap the 2-bit counter, then HLT freezes it.
    cnt_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    mem_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      set_instr(4'b0001, 2'b00);
      for (int i = 0; i < 4; i++) step();
      chk("nop_cnt", instr_count, cnt_seq[n]);
    end
    set_instr(4'b1111, 2'b00);
    for (int i = 0; i < 4; i++) step();
    chk("hlt_state", {halted, instr_count}, {1'b1, 2'd1});
    do_reset();

    for (int c = 0; c < 4000; c++) begin
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 399) == 0) begin
        do_reset();
      end
      if (m_start) pick_instr();
      mem_ready = ($urandom_range(0, 9) < 7);
      zero      = 1'($urandom);
      carry     = 1'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
